// File: rtl/addersub_seq.sv
// ---------------------------------------------------------------------------
// addersub_seq
//
// Multi-cycle adder/subtractor. A WIDTH-bit operation is carried out CHUNK
// bits per clock through a small CHUNK-bit adder. The carry (or borrow) is
// passed from one chunk to the next in a register. One operation takes
// N = WIDTH/CHUNK RUN cycles, plus one accept cycle and one DONE cycle.
//
//   add : {cout, sum} = a + b + cin
//   sub : {cout, sum} = a + ~b + ~cin   (cout = 1 means no borrow)
//   ovf : signed overflow, computed as carry-into-MSB XOR carry-out-of-MSB
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per clock; must divide WIDTH exactly
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation
//   in_valid   operands valid           in_ready   block accepts operands (IDLE)
//   a, b       operands                 cin        carry-in / borrow-in
//   op         0 = add, 1 = subtract
//   out_valid  result valid (DONE)      out_ready  consumer takes the result
//   sum        result                   cout       carry-out / not-borrow
//   ovf        signed overflow
//
// Optional build macro:
//   ADDERSUB_SAT_EN  when defined, an overflowing result is replaced by the
//                    signed saturation limit for the sign of A. ovf still
//                    reads 1 and cout keeps the raw carry.
// ---------------------------------------------------------------------------
module addersub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow from the MSB column. The carry into the MSB is
    // recovered as a ^ b ^ s of that column, so the per-chunk adder does not
    // have to expose internal carries.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic c_out
    );
        logic c_into_msb;
        c_into_msb = a_msb ^ b_msb ^ s_msb;
        return c_into_msb ^ c_out;
    endfunction

`ifdef ADDERSUB_SAT_EN
    // Signed saturation limit selected by the sign of operand A.
    function automatic logic [WIDTH-1:0] sat_limit(input logic a_neg);
        logic [WIDTH-1:0] lim;
        if (a_neg) begin
            lim = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            lim = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return lim;
    endfunction
`endif

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;        // effective B: b for add, ~b for sub
    logic             carry_r;    // carry into the current chunk
    logic [KW-1:0]    k_r;        // current chunk index
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [31:0]      base_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_full_s;
    logic [CHUNK-1:0] chunk_res_s;
    logic             chunk_cout_s;
    logic             ovf_s;

    // Chunk datapath: a CHUNK-bit adder working on slice k of the operands.
    assign base_s       = 32'(k_r) * 32'(CHUNK);
    assign a_chunk_s    = a_r[base_s +: CHUNK];
    assign b_chunk_s    = b_r[base_s +: CHUNK];
    assign chunk_full_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s}
                        + {{CHUNK{1'b0}}, carry_r};
    assign chunk_res_s  = chunk_full_s[CHUNK-1:0];
    assign chunk_cout_s = chunk_full_s[CHUNK];

    // The result MSB only exists in the last chunk, so ovf_s is only
    // meaningful (and only sampled) when k_r == K_LAST.
    assign ovf_s = ovf_calc(a_r[WIDTH-1], b_r[WIDTH-1],
                            chunk_res_s[CHUNK-1], chunk_cout_s);

    // Control FSM plus operand, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            k_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        // Subtraction is folded into the operands here, so
                        // RUN only ever adds.
                        a_r        <= a;
                        b_r        <= op ? ~b : b;
                        carry_r    <= op ? ~cin : cin;
                        k_r        <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_RUN;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    sum_r[base_s +: CHUNK] <= chunk_res_s;
                    carry_r                <= chunk_cout_s;
                    if (k_r == K_LAST) begin
                        cout_r      <= chunk_cout_s;
                        ovf_r       <= ovf_s;
`ifdef ADDERSUB_SAT_EN
                        // Overrides the chunk write above on overflow.
                        if (ovf_s) begin
                            sum_r <= sat_limit(a_r[WIDTH-1]);
                        end else begin
                            sum_r[base_s +: CHUNK] <= chunk_res_s;
                        end
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        k_r         <= k_r + K_ONE;
                    end
                end

                ST_DONE: begin
                    // Outputs hold until the consumer takes them.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end

                default: begin
                    // Recover from an illegal state encoding without
                    // producing a result.
                    state_r     <= ST_IDLE;
                    k_r         <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_addersub_seq.sv
// ---------------------------------------------------------------------------
// tb_addersub_seq
//
// Bench for addersub_seq. It uses two instances:
//   dut8: WIDTH=8, CHUNK=2, so N=4
//   dut1: WIDTH=8, CHUNK=8, so N=1
//
// The bench works from a vector table and a reference model. It pushes the
// expected results to a scoreboard queue when it drives an operation. It pops
// them when out_valid rises.
// ---------------------------------------------------------------------------
module tb_addersub_seq;

`ifdef ADDERSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       op;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       cin, op;
    logic       iv8, ir8, ov8, or8, cout8, ovf8;
    logic [7:0] sum8;
    logic       iv1, ir1, ov1, or1, cout1, ovf1;
    logic [7:0] sum1;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t sb_q[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    addersub_seq #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    addersub_seq #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-word reference model written directly from the arithmetic rules.
    function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic mcin, input logic mop);
        vec_t       r;
        logic [7:0] eb;
        logic       ec;
        logic [8:0] full;
        eb    = mop ? ~mb : mb;
        ec    = mop ? ~mcin : mcin;
        full  = {1'b0, ma} + {1'b0, eb} + {8'h00, ec};
        r.a   = ma;
        r.b   = mb;
        r.cin = mcin;
        r.op  = mop;
        r.c   = full[8];
        r.s   = full[7:0];
        r.v   = (ma[7] == eb[7]) && (full[7] != ma[7]);
        if (SAT && r.v) r.s = ma[7] ? 8'h80 : 8'h7F;
        return r;
    endfunction

    // Runs one operation on dut8 (sel=0) or dut1 (sel=1). It checks the
    // latency, the result and the return to IDLE. The result is held for
    // 'hold' cycles with in_valid pulsing before it is released.
    task automatic run_op(input bit sel, input vec_t v, input int exp_lat,
                          input int hold);
        vec_t e;
        int   cnt;
        chk("in_ready_idle", sel ? ir1 : ir8, 1);
        a = v.a; b = v.b; cin = v.cin; op = v.op;
        if (sel) iv1 = 1'b1; else iv8 = 1'b1;
        @(posedge clk);
        sb_q.push_back(v);
        #1;
        iv8 = 1'b0; iv1 = 1'b0;
        // Scramble the operands: after acceptance they must have no effect.
        a = ~v.a; b = 8'($urandom); cin = ~v.cin; op = ~v.op;
        chk("in_ready_run", sel ? ir1 : ir8, 0);
        cnt = 0;
        while (!(sel ? ov1 : ov8) && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, exp_lat);
        e = sb_q.pop_front();
        chk("sum",  sel ? sum1  : sum8,  e.s);
        chk("cout", sel ? cout1 : cout8, e.c);
        chk("ovf",  sel ? ovf1  : ovf8,  e.v);
        for (int i = 0; i < hold; i++) begin
            if (sel) iv1 = i[0]; else iv8 = i[0];
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", sel ? ov1 : ov8, 1);
            chk("hold_ready", sel ? ir1 : ir8, 0);
            chk("hold_sum",   sel ? sum1 : sum8, e.s);
            chk("hold_cout",  sel ? cout1 : cout8, e.c);
            chk("hold_ovf",   sel ? ovf1 : ovf8, e.v);
        end
        iv8 = 1'b0; iv1 = 1'b0;
        if (sel) or1 = 1'b1; else or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0; or1 = 1'b0;
        chk("release_valid", sel ? ov1 : ov8, 0);
        chk("release_ready", sel ? ir1 : ir8, 1);
    endtask

    initial begin
        int quiet;
        rst = 1'b1; iv8 = 1'b0; iv1 = 1'b0; or8 = 1'b0; or1 = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; op = 1'b0;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
        tbl[5] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{8'h7F, 8'hFF, 1'b0, 1'b1, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        tbl[9] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready8",  ir8,   1);
        chk("rst_out_valid8", ov8,   0);
        chk("rst_sum8",       sum8,  8'h00);
        chk("rst_cout8",      cout8, 0);
        chk("rst_ovf8",       ovf8,  0);
        chk("rst_in_ready1",  ir1,   1);
        chk("rst_out_valid1", ov1,   0);

        for (int i = 0; i < 10; i++) run_op(1'b0, tbl[i], 4, 0);

        for (int i = 0; i < 16; i++)
            run_op(1'b0, model(8'($urandom), 8'($urandom), 1'($urandom),
                               1'($urandom)), 4, 0);

        // Backpressure: hold DONE for 5 cycles while in_valid toggles.
        run_op(1'b0, model(8'h9A, 8'h37, 1'b1, 1'b1), 4, 5);
        // Check that no operation was started behind the held result.
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ov8) quiet++;
        end
        chk("no_ghost_op", quiet, 0);

        // Reset during RUN cycle 2 aborts the operation with no output.
        a = 8'h12; b = 8'h34; cin = 1'b0; op = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready",  ir8,   1);
        chk("abort_out_valid", ov8,   0);
        chk("abort_sum",       sum8,  8'h00);
        chk("abort_cout",      cout8, 0);
        chk("abort_ovf",       ovf8,  0);
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov8) quiet++;
        end
        chk("abort_no_output", quiet, 0);
        run_op(1'b0, tbl[2], 4, 0);

        // Single-chunk instance: N = 1.
        run_op(1'b1, tbl[5], 1, 0);
        run_op(1'b1, tbl[3], 1, 2);
        for (int i = 0; i < 6; i++)
            run_op(1'b1, model(8'($urandom), 8'($urandom), 1'($urandom),
                               1'($urandom)), 1, 0);

        chk("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addersub_seq.md
Name: addersub_seq

Overview:
- Parametrised, multi-cycle adder/subtractor. Successor to the 2-bit combinational addersub.
- Processes WIDTH-bit operands CHUNK bits per clock, with carry/borrow chained between chunks.
- Valid/ready handshake on both input and output. Reports carry-out and signed overflow.
- Serves datapaths that trade latency for a small, fixed-width adder.

Parameters:
- WIDTH, 8: operand and result width in bits; must be >= 2.
- CHUNK, 2: bits processed per clock; must divide WIDTH exactly. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  add: carry-out. Sub: 1 = no borrow, 0 = borrow.
- ovf  out  1  signed (two's complement) overflow.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - Internal operand and carry registers are cleared.
  - Reset overrides every other input and aborts any operation in progress with no output produced.
- Arithmetic:
  - Add: {cout, sum} = a + b + cin.
  - Sub: {cout, sum} = a + ~b + ~cin, i.e. a - b - cin.
  - ovf = (sign of A == sign of effective B) && (sign of sum != sign of A), where effective B is b for add and ~b for sub.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
    - On in_valid && in_ready: latch a, b, op, and the initial carry (cin for add, ~cin for sub); clear chunk index k; go to RUN.
  - RUN: in_ready = 0, out_valid = 0.
    - Each clock, compute chunk k, bits [k*CHUNK +: CHUNK], from the latched A, the effective B and the carry register.
    - Write that chunk into the sum register and update the carry register; k increments.
    - After chunk N-1 is computed: cout = final carry, ovf is computed from the MSB and the carry into the MSB, and the state goes to DONE.
  - DONE: out_valid = 1, in_ready = 0.
    - sum, cout and ovf are held stable for as long as out_ready = 0.
    - On out_ready = 1: go to IDLE.
- Latency and throughput:
  - out_valid is first high in the cycle following the N-th rising edge after the accepting edge.
  - One operation per N+2 cycles at best: accept, N RUN cycles, one DONE cycle. Operations never overlap.
- Input handling:
  - in_valid is ignored outside IDLE.
  - Operands change after acceptance have no effect.
- Outputs in IDLE:
  - sum, cout and ovf keep the last result until the next operation overwrites them chunk by chunk.
  - They are valid only while out_valid = 1.
- CHUNK == WIDTH: N = 1, a single RUN cycle.
- Wrap-around: results are modulo 2^WIDTH unless the optional feature is enabled.

Optional Feature:
- Macro: ADDERSUB_SAT_EN.
- Defined:
  - When ovf = 1 at completion, sum is replaced by the signed saturation limit: 0111..1 if A is non-negative, 1000..0 if A is negative.
  - ovf still reports 1. cout is unchanged, i.e. the raw carry.
  - Saturation is applied in the transition to DONE, so latency is unchanged.
- Not defined: sum wraps modulo 2^WIDTH and ovf is report-only.

Test Plan (WIDTH=8, CHUNK=2, so N=4):
- rst=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, sum=0x00, cout=0, ovf=0.
- Add: a=0xFF, b=0x01, cin=0 -> out_valid after 4 edges; sum=0x00, cout=1, ovf=0.
- Add: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
  - With ADDERSUB_SAT_EN: sum=0x7F, ovf=1.
- Sub: a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0.
- Sub: a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
  - With ADDERSUB_SAT_EN: sum=0x80.
- Sub: a=0x10, b=0x01, cin=1 -> sum=0x0E, cout=1, ovf=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> sum, cout, ovf, out_valid stable; in_ready=0; in_valid pulses ignored.
  - Assert rst during RUN cycle 2 -> next cycle IDLE, out_valid=0, sum=0x00, no result emitted.
- Compile a second instance with CHUNK=8 -> N=1; a=0x3C, b=0x0F, add, cin=1 -> sum=0x4C, cout=0, ovf=0, out_valid high after 1 edge.
